alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width (even power of two, >= 8).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operation offered; in_ready  output  1  operation accepted when both high.
REQ-005 SHALL have ports A, B  input  WIDTH  operands; Op  input  5  decoded ALU operation.
REQ-006 SHALL have ports Cin, invA, invB, sign  input  1 each  carry-in, invert A, invert B, signed mode.
REQ-007 SHALL have port out_valid  output  1  result present; out_ready  input  1  result consumed when both high.
REQ-008 SHALL have ports Out  output  WIDTH  result; Ofl, Zero, err  output  1 each  overflow, Out==0, illegal Op.
REQ-009 SHALL have port err_sticky  output  1  set by any delivered err=1 result, cleared only by rst.

Function
REQ-010 SHALL be a two-stage pipeline: S1 registers accepted inputs, S2 registers computed result; accept-to-out_valid latency exactly 2 cycles with out_ready held high.
REQ-011 SHALL drive in_ready = !s1_valid | s1 can advance; s1 advances when !s2_valid | out_ready.
REQ-012 SHALL hold Out/Ofl/Zero/err stable while out_valid=1 and out_ready=0; no result lost or duplicated.
REQ-013 SHALL sustain one operation per cycle with in_valid and out_ready continuously high.
REQ-014 SHALL form Ain = invA ? ~A : A, Bin = invB ? ~B : B, Sum = Ain + Bin + Cin (WIDTH+1 bits).
REQ-015 SHALL compute: 00100 Out=Sum; 00110 Ain^Bin; 00111 Ain&Bin; 01001 bit-reverse of A.
REQ-016 SHALL compute shifts by B[log2(WIDTH)-1:0], Cin ignored: 00000 rotate left, 00001 shift left, 01000 rotate right, 00011 logical shift right, all on A.
REQ-017 SHALL compute compares as 0/1 in Out[0], upper bits 0: 01010 A==B; 01011 signed A<B; 01100 signed A<=B; 01101 carry-out of A+B+Cin.
REQ-018 SHALL compute 10000 Out = {A[WIDTH/2-1:0], B[WIDTH/2-1:0]}.
REQ-019 SHALL set Ofl only for Op 00100: sign=1 signed overflow of Sum; sign=0 Sum carry-out; Ofl=0 otherwise.
REQ-020 SHALL set Zero = (Out == 0) for every delivered result.

Reset
REQ-021 SHALL, on rst, clear s1_valid, s2_valid, err_sticky; in_ready=1, out_valid=0, Out=0, Ofl=0, Zero=0, err=0 next cycle.
REQ-022 SHALL discard in-flight operations on rst asserted mid-stream; an operation offered during rst is not accepted.

Configuration
REQ-023 SHALL honour macro ALU_OP_CHECK_EN: defined, any Op outside REQ-015..018 gives Out=0, Ofl=0, err=1; undefined, such Op gives Out=0, err=0, err_sticky never sets.

Structure
REQ-024 SHALL take Op encodings as named constants from shared package alu_pkg, used also by the ALU control decoder.
REQ-025 SHALL place combinational result logic in sub-module alu_core; alu_exec holds pipeline registers and handshake only.

Verification
REQ-026 Op=00100, A=16'h7FFF, B=16'h0001, Cin=0, sign=1 -> 2 cycles later Out=16'h8000, Ofl=1, Zero=0.
REQ-027 Op=00100, invA=1, Cin=1, A=5, B=3 (subi form) -> Out=16'hFFFE, Ofl=0; then A=3,B=3 -> Out=0, Zero=1.
REQ-028 Op=01011, invB=1, Cin=1, A=16'hFFFF, B=1 -> Out=1; Op=01000, A=16'h0001, B=1 -> Out=16'h8000.
REQ-029 Back-to-back 4 ops, out_ready low 3 cycles after first result -> in_ready drops after S1/S2 fill, results delivered in order, values unchanged while stalled.
REQ-030 Op=11111 with ALU_OP_CHECK_EN -> err=1, err_sticky=1 until rst; without macro -> Out=0, err=0.
REQ-031 rst asserted with both stages valid -> next cycle out_valid=0, in_ready=1, no stale result emitted afterwards.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: Op encodings, result flag bundle and the legal-op
// helper used by both the datapath and the ALU control decoder.
package alu_pkg;

  localparam logic [4:0] OP_ROL  = 5'b00000;
  localparam logic [4:0] OP_SLL  = 5'b00001;
  localparam logic [4:0] OP_SRL  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_XOR  = 5'b00110;
  localparam logic [4:0] OP_AND  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_BREV = 5'b01001;
  localparam logic [4:0] OP_SEQ  = 5'b01010;
  localparam logic [4:0] OP_SLT  = 5'b01011;
  localparam logic [4:0] OP_SLE  = 5'b01100;
  localparam logic [4:0] OP_SCO  = 5'b01101;
  localparam logic [4:0] OP_PACK = 5'b10000;

  typedef struct packed {
    logic ofl;
    logic zero;
    logic err;
  } alu_flags_t;

  function automatic logic op_legal(input logic [4:0] op);
    case (op)
      OP_ROL, OP_SLL, OP_SRL, OP_ADD, OP_XOR, OP_AND, OP_ROR,
      OP_BREV, OP_SEQ, OP_SLT, OP_SLE, OP_SCO, OP_PACK: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU result and flags for one operation.
// ALU_OP_CHECK_EN: when defined, unknown Op codes raise err.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       op,
  input  logic             cin,
  input  logic             inv_a,
  input  logic             inv_b,
  input  logic             sign,
  output logic [WIDTH-1:0] out,
  output alu_flags_t       flags
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] ain;
  logic [WIDTH-1:0] bin;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   sh;
  logic [SHW-1:0]   idx_l;
  logic [SHW-1:0]   idx_r;
  logic [WIDTH-1:0] rol;
  logic [WIDTH-1:0] ror;
  logic [WIDTH-1:0] brev;
  logic             sco;
  logic             slt;
  logic             sle;

  always_comb begin
    ain   = inv_a ? ~a : a;
    bin   = inv_b ? ~b : b;
    sum   = {1'b0, ain} + {1'b0, bin} + {{WIDTH{1'b0}}, cin};
    sh    = b[SHW-1:0];
    rol   = '0;
    ror   = '0;
    brev  = '0;
    idx_l = '0;
    idx_r = '0;
    // Power-of-two width lets the index wrap naturally for rotates.
    for (int i = 0; i < WIDTH; i++) begin
      idx_l   = SHW'(i) - sh;
      idx_r   = SHW'(i) + sh;
      rol[i]  = a[idx_l];
      ror[i]  = a[idx_r];
      brev[i] = a[WIDTH-1-i];
    end
    sco = ({1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin}) > {1'b0, {WIDTH{1'b1}}};
    slt = $signed(a) < $signed(b);
    sle = $signed(a) <= $signed(b);
  end

  always_comb begin
    out   = '0;
    flags = '0;
    case (op)
      OP_ADD: begin
        out       = sum[WIDTH-1:0];
        flags.ofl = sign ? ((ain[WIDTH-1] == bin[WIDTH-1]) && (sum[WIDTH-1] != ain[WIDTH-1]))
                         : sum[WIDTH];
      end
      OP_XOR:  out = ain ^ bin;
      OP_AND:  out = ain & bin;
      OP_BREV: out = brev;
      OP_ROL:  out = rol;
      OP_SLL:  out = a << sh;
      OP_ROR:  out = ror;
      OP_SRL:  out = a >> sh;
      OP_SEQ:  out = {{(WIDTH-1){1'b0}}, (a == b)};
      OP_SLT:  out = {{(WIDTH-1){1'b0}}, slt};
      OP_SLE:  out = {{(WIDTH-1){1'b0}}, sle};
      OP_SCO:  out = {{(WIDTH-1){1'b0}}, sco};
      OP_PACK: out = {a[WIDTH/2-1:0], b[WIDTH/2-1:0]};
      default: out = '0;
    endcase
`ifdef ALU_OP_CHECK_EN
    flags.err = !op_legal(op);
`else
    flags.err = 1'b0;
`endif
    flags.zero = (out == '0);
  end

endmodule

// File: rtl/alu_exec.sv
// Two-stage pipelined ALU execute block: S1 holds accepted operands, S2 the result.
// ALU_OP_CHECK_EN (see alu_core) enables err/err_sticky on unknown Op codes.
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       Op,
  input  logic             Cin,
  input  logic             invA,
  input  logic             invB,
  input  logic             sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             Ofl,
  output logic             Zero,
  output logic             err,
  output logic             err_sticky
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [4:0]       s1_op;
  logic             s1_cin;
  logic             s1_inv_a;
  logic             s1_inv_b;
  logic             s1_sign;
  logic             s1_adv;
  logic [WIDTH-1:0] core_out;
  alu_flags_t       core_flags;

  // Valid/ready: a transfer happens on a rising edge where valid and ready are
  // both high; a stalled result holds its data until out_ready rises.
  assign s1_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s1_adv;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a     (s1_a),
    .b     (s1_b),
    .op    (s1_op),
    .cin   (s1_cin),
    .inv_a (s1_inv_a),
    .inv_b (s1_inv_b),
    .sign  (s1_sign),
    .out   (core_out),
    .flags (core_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      out_valid  <= 1'b0;
      Out        <= '0;
      Ofl        <= 1'b0;
      Zero       <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_a     <= A;
          s1_b     <= B;
          s1_op    <= Op;
          s1_cin   <= Cin;
          s1_inv_a <= invA;
          s1_inv_b <= invB;
          s1_sign  <= sign;
        end
      end
      if (s1_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          Out  <= core_out;
          Ofl  <= core_flags.ofl;
          Zero <= core_flags.zero;
          err  <= core_flags.err;
        end
      end
      if (out_valid && out_ready && err) begin
        err_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: directed cases plus randomized traffic against a reference model.
module tb_alu_exec;

  localparam int W = 16;
`ifdef ALU_OP_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif
  localparam logic [4:0] OPS [13] = '{5'b00000, 5'b00001, 5'b00011, 5'b00100, 5'b00110,
                                      5'b00111, 5'b01000, 5'b01001, 5'b01010, 5'b01011,
                                      5'b01100, 5'b01101, 5'b10000};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [4:0]   op = '0;
  logic         cin = 1'b0;
  logic         inv_a = 1'b0;
  logic         inv_b = 1'b0;
  logic         sign = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         ofl;
  logic         zero;
  logic         err;
  logic         err_sticky;

  int           tests_run = 0;
  int           fails = 0;
  int           delivered = 0;
  logic [W+2:0] exp_q[$];
  logic [W+2:0] last_res = '0;
  logic [W+2:0] held = '0;
  logic         stalled = 1'b0;
  logic         exp_sticky = 1'b0;

  alu_exec #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (a),
    .B          (b),
    .Op         (op),
    .Cin        (cin),
    .invA       (inv_a),
    .invB       (inv_b),
    .sign       (sign),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Out        (out_data),
    .Ofl        (ofl),
    .Zero       (zero),
    .err        (err),
    .err_sticky (err_sticky)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    tests_run++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  // Reference model: {Out, Ofl, Zero, err} from plain integer arithmetic.
  function automatic logic [W+2:0] ref_model(input logic [4:0] f_op, input logic [W-1:0] f_a,
                                             input logic [W-1:0] f_b, input logic f_cin,
                                             input logic f_ia, input logic f_ib, input logic f_sg);
    logic [W-1:0] ain, bin, o;
    logic         of, er;
    logic [31:0]  t;
    int           u, s, sh;
    ain = f_ia ? ~f_a : f_a;
    bin = f_ib ? ~f_b : f_b;
    o = '0; of = 1'b0; er = 1'b0;
    sh = int'(f_b[3:0]);
    case (f_op)
      5'b00100: begin
        u  = int'(ain) + int'(bin) + int'(f_cin);
        s  = int'($signed(ain)) + int'($signed(bin)) + int'(f_cin);
        o  = u[15:0];
        of = f_sg ? (s > 32767 || s < -32768) : (u > 65535);
      end
      5'b00110: o = ain ^ bin;
      5'b00111: o = ain & bin;
      5'b01001: for (int i = 0; i < W; i++) o[W-1-i] = f_a[i];
      5'b00000: begin t = {16'h0, f_a} << sh; o = t[15:0] | t[31:16]; end
      5'b00001: o = f_a << sh;
      5'b01000: begin t = {f_a, 16'h0} >> sh; o = t[31:16] | t[15:0]; end
      5'b00011: o = f_a >> sh;
      5'b01010: o = (f_a == f_b) ? 16'd1 : 16'd0;
      5'b01011: o = (int'($signed(f_a)) < int'($signed(f_b))) ? 16'd1 : 16'd0;
      5'b01100: o = (int'($signed(f_a)) <= int'($signed(f_b))) ? 16'd1 : 16'd0;
      5'b01101: o = (int'(f_a) + int'(f_b) + int'(f_cin) > 65535) ? 16'd1 : 16'd0;
      5'b10000: o = {f_a[7:0], f_b[7:0]};
      default:  er = ERR_EN;
    endcase
    return {o, of, (o == 16'h0), er};
  endfunction

  // scoreboard / monitor
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stalled    = 1'b0;
      exp_sticky = 1'b0;
    end else begin
      check("err_sticky", {31'b0, err_sticky}, {31'b0, exp_sticky});
      if (stalled) begin
        check("hold_valid", {31'b0, out_valid}, 32'd1);
        check("hold_data", {13'b0, out_data, ofl, zero, err}, {13'b0, held});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", {31'b0, out_valid}, 32'd0);
        end else begin
          logic [W+2:0] e;
          e = exp_q.pop_front();
          check("result", {13'b0, out_data, ofl, zero, err}, {13'b0, e});
          last_res = {out_data, ofl, zero, err};
          delivered++;
          if (e[0]) exp_sticky = 1'b1;
        end
      end
      stalled = out_valid && !out_ready;
      held    = {out_data, ofl, zero, err};
      if (in_valid && in_ready)
        exp_q.push_back(ref_model(op, a, b, cin, inv_a, inv_b, sign));
    end
  end

  // driver tasks
  task automatic set_op(input logic [4:0] t_op, input logic [W-1:0] t_a, input logic [W-1:0] t_b,
                        input logic t_c, input logic t_ia, input logic t_ib, input logic t_sg);
    op = t_op; a = t_a; b = t_b; cin = t_c; inv_a = t_ia; inv_b = t_ib; sign = t_sg;
  endtask

  task automatic set_random();
    op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : OPS[$urandom_range(0, 12)];
    a = 16'($urandom()); b = 16'($urandom());
    cin = 1'($urandom_range(0, 1)); inv_a = 1'($urandom_range(0, 1));
    inv_b = 1'($urandom_range(0, 1)); sign = 1'($urandom_range(0, 1));
  endtask

  task automatic run_one(input logic [4:0] t_op, input logic [W-1:0] t_a, input logic [W-1:0] t_b,
                         input logic t_c, input logic t_ia, input logic t_ib, input logic t_sg);
    @(posedge clk); #1;
    set_op(t_op, t_a, t_b, t_c, t_ia, t_ib, t_sg);
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk); check("accept", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk); check("latency_1", {31'b0, out_valid}, 32'd0);
    @(negedge clk); check("latency_2", {31'b0, out_valid}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1; rst = 1'b1;
    repeat (n) @(posedge clk);
    #1; rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic reset_checks();
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out", {16'b0, out_data}, 32'd0);
    check("rst_ofl", {31'b0, ofl}, 32'd0);
    check("rst_zero", {31'b0, zero}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_sticky", {31'b0, err_sticky}, 32'd0);
  endtask

  initial begin
    logic saw_low;
    int   d0;
    do_reset(3);
    reset_checks();

    run_one(5'b00100, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
    check("add_ovf_out", {16'b0, last_res[18:3]}, 32'h8000);
    check("add_ovf_ofl", {31'b0, last_res[2]}, 32'd1);
    check("add_ovf_zero", {31'b0, last_res[1]}, 32'd0);
    run_one(5'b00100, 16'd5, 16'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    check("subi_out", {16'b0, last_res[18:3]}, 32'hFFFE);
    check("subi_ofl", {31'b0, last_res[2]}, 32'd0);
    run_one(5'b00100, 16'd3, 16'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    check("subi_zero_out", {16'b0, last_res[18:3]}, 32'd0);
    check("subi_zero_flag", {31'b0, last_res[1]}, 32'd1);
    run_one(5'b01011, 16'hFFFF, 16'd1, 1'b1, 1'b0, 1'b1, 1'b1);
    check("slt_out", {16'b0, last_res[18:3]}, 32'd1);
    run_one(5'b01000, 16'h0001, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ror_out", {16'b0, last_res[18:3]}, 32'h8000);
    run_one(5'b00000, 16'h8001, 16'd15, 1'b1, 1'b0, 1'b0, 1'b0);
    check("rol_max_out", {16'b0, last_res[18:3]}, 32'hC000);
    run_one(5'b10000, 16'h12AB, 16'h34CD, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pack_out", {16'b0, last_res[18:3]}, 32'hABCD);
    run_one(5'b01001, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    check("brev_out", {16'b0, last_res[18:3]}, 32'h8000);

    // Illegal op and sticky error
    run_one(5'b11111, 16'h1234, 16'h5678, 1'b1, 1'b0, 1'b0, 1'b0);
    check("illegal_out", {16'b0, last_res[18:3]}, 32'd0);
    check("illegal_err", {31'b0, last_res[0]}, {31'b0, ERR_EN});
    check("sticky_set", {31'b0, err_sticky}, {31'b0, ERR_EN});
    run_one(5'b00110, 16'h00FF, 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0);
    check("sticky_hold", {31'b0, err_sticky}, {31'b0, ERR_EN});
    do_reset(1);
    reset_checks();

    // Back-to-back with an output stall
    saw_low = 1'b0;
    d0 = delivered;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          @(posedge clk); #1;
          set_random();
          op = OPS[$urandom_range(0, 12)];
          in_valid = 1'b1;
          for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (in_ready) break;
          end
        end
        @(posedge clk); #1; in_valid = 1'b0;
      end
      begin
        out_ready = 1'b1;
        for (int t = 0; t < 20; t++) begin
          @(negedge clk);
          if (out_valid) break;
        end
        @(posedge clk); #1; out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          if (!in_ready) saw_low = 1'b1;
        end
        @(posedge clk); #1; out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    check("stall_in_ready_low", {31'b0, saw_low}, 32'd1);
    check("stall_delivered", delivered - d0, 32'd4);
    check("stall_queue_empty", exp_q.size(), 32'd0);

    // Randomized traffic with random backpressure
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      set_random();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1; in_valid = 1'b0; out_ready = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk);
      if (exp_q.size() == 0 && !out_valid) break;
    end
    #1;
    check("random_drain", exp_q.size(), 32'd0);

    // Reset with both stages full and an op offered during reset
    @(posedge clk); #1;
    set_random(); op = OPS[3]; in_valid = 1'b1; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    reset_checks();
    repeat (6) begin
      @(negedge clk);
      check("no_stale", {31'b0, out_valid}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
